// File: rtl/display_decoder.sv
// Binary hh:mm:ss to six registered BCD digits with range clamping.
// Optional DISPLAY_DECODER_SEG_EN adds active-low 7-seg outputs.
module display_decoder #(
  parameter int HRS_LIMIT = 24,
  parameter int MS_LIMIT  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] numhrs,
  input  logic [5:0] nummin,
  input  logic [5:0] numsec,
  output logic [3:0] outhrstens,
  output logic [3:0] outhrsones,
  output logic [3:0] outmintens,
  output logic [3:0] outminones,
  output logic [3:0] outsectens,
  output logic [3:0] outsecones,
  output logic       range_err
`ifdef DISPLAY_DECODER_SEG_EN
  ,
  output logic [6:0] seg_hrstens,
  output logic [6:0] seg_hrsones,
  output logic [6:0] seg_mintens,
  output logic [6:0] seg_minones,
  output logic [6:0] seg_sectens,
  output logic [6:0] seg_secones
`endif
);

  localparam logic [5:0] HLIM = 6'(HRS_LIMIT);
  localparam logic [5:0] MLIM = 6'(MS_LIMIT);
  localparam logic [5:0] HMAX = 6'(HRS_LIMIT - 1);
  localparam logic [5:0] MMAX = 6'(MS_LIMIT - 1);

  // Single-pass divide by 10: pick the tens bucket, subtract it.
  function automatic logic [7:0] to_bcd(
    input logic [5:0] v
  );
    logic [3:0] t;
    logic [5:0] s;
    if (v >= 6'd50) begin
      t = 4'd5; s = 6'd50;
    end else if (v >= 6'd40) begin
      t = 4'd4; s = 6'd40;
    end else if (v >= 6'd30) begin
      t = 4'd3; s = 6'd30;
    end else if (v >= 6'd20) begin
      t = 4'd2; s = 6'd20;
    end else if (v >= 6'd10) begin
      t = 4'd1; s = 6'd10;
    end else begin
      t = 4'd0; s = 6'd0;
    end
    return {t, 4'(v - s)};
  endfunction

  logic [5:0] hrs6;
  logic       hrs_bad;
  logic       min_bad;
  logic       sec_bad;
  logic [5:0] hrs_c;
  logic [5:0] min_c;
  logic [5:0] sec_c;
  logic [7:0] hrs_d;
  logic [7:0] min_d;
  logic [7:0] sec_d;

  always_comb begin
    hrs6    = {1'b0, numhrs};
    hrs_bad = hrs6 >= HLIM;
    min_bad = nummin >= MLIM;
    sec_bad = numsec >= MLIM;
    hrs_c   = hrs_bad ? HMAX : hrs6;
    min_c   = min_bad ? MMAX : nummin;
    sec_c   = sec_bad ? MMAX : numsec;
    hrs_d   = to_bcd(hrs_c);
    min_d   = to_bcd(min_c);
    sec_d   = to_bcd(sec_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outhrstens <= 4'd0;
      outhrsones <= 4'd0;
      outmintens <= 4'd0;
      outminones <= 4'd0;
      outsectens <= 4'd0;
      outsecones <= 4'd0;
      range_err  <= 1'b0;
    end else if (en) begin
      outhrstens <= hrs_d[7:4];
      outhrsones <= hrs_d[3:0];
      outmintens <= min_d[7:4];
      outminones <= min_d[3:0];
      outsectens <= sec_d[7:4];
      outsecones <= sec_d[3:0];
      range_err  <= hrs_bad | min_bad | sec_bad;
    end
  end

`ifdef DISPLAY_DECODER_SEG_EN
  localparam logic [6:0] SEG0 = 7'b1000000;

  // Common-anode pattern, bit 6 = g down to bit 0 = a.
  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_hrstens <= SEG0;
      seg_hrsones <= SEG0;
      seg_mintens <= SEG0;
      seg_minones <= SEG0;
      seg_sectens <= SEG0;
      seg_secones <= SEG0;
    end else if (en) begin
      seg_hrstens <= seg7(hrs_d[7:4]);
      seg_hrsones <= seg7(hrs_d[3:0]);
      seg_mintens <= seg7(min_d[7:4]);
      seg_minones <= seg7(min_d[3:0]);
      seg_sectens <= seg7(sec_d[7:4]);
      seg_secones <= seg7(sec_d[3:0]);
    end
  end
`endif

endmodule

// File: tb/tb_display_decoder.sv
// Directed self-checking bench for display_decoder.
// Build with DISPLAY_DECODER_SEG_EN to also check 7-seg outputs.
module tb_display_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] numhrs;
  logic [5:0] nummin;
  logic [5:0] numsec;
  logic [3:0] outhrstens;
  logic [3:0] outhrsones;
  logic [3:0] outmintens;
  logic [3:0] outminones;
  logic [3:0] outsectens;
  logic [3:0] outsecones;
  logic       range_err;
`ifdef DISPLAY_DECODER_SEG_EN
  logic [6:0] seg_hrstens;
  logic [6:0] seg_hrsones;
  logic [6:0] seg_mintens;
  logic [6:0] seg_minones;
  logic [6:0] seg_sectens;
  logic [6:0] seg_secones;
`endif

  int n_cmp;
  int n_bad;

  display_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .numhrs     (numhrs),
    .nummin     (nummin),
    .numsec     (numsec),
    .outhrstens (outhrstens),
    .outhrsones (outhrsones),
    .outmintens (outmintens),
    .outminones (outminones),
    .outsectens (outsectens),
    .outsecones (outsecones),
    .range_err  (range_err)
`ifdef DISPLAY_DECODER_SEG_EN
    ,
    .seg_hrstens(seg_hrstens),
    .seg_hrsones(seg_hrsones),
    .seg_mintens(seg_mintens),
    .seg_minones(seg_minones),
    .seg_sectens(seg_sectens),
    .seg_secones(seg_secones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] dig;
  assign dig = {outhrstens, outhrsones,
                outmintens, outminones,
                outsectens, outsecones};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h,
                       input int m,
                       input int s);
    numhrs = 5'(h);
    nummin = 6'(m);
    numsec = 6'(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en    = 1'b1;
    drive(17, 42, 33);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dig !== 24'h0 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: dig=%h err=%b want 000000 0",
               dig, range_err);
    end
`ifdef DISPLAY_DECODER_SEG_EN
    n_cmp++;
    if (seg_hrstens !== 7'b1000000 ||
        seg_secones !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_seg: %b %b want 1000000",
               seg_hrstens, seg_secones);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    drive(23, 59, 59);
    tick();
    n_cmp++;
    if (dig !== 24'h235959 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_max: dig=%h err=%b want 235959 0",
               dig, range_err);
    end
    drive(0, 0, 0);
    tick();
    n_cmp++;
    if (dig !== 24'h000000 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_zero: dig=%h err=%b want 000000 0",
               dig, range_err);
    end
  endtask

  task automatic test_boundaries();
    int          hv [4] = '{9, 10, 19, 20};
    logic [23:0] ev [4] = '{24'h091010, 24'h101010,
                            24'h191010, 24'h201010};
    for (int i = 0; i < 4; i++) begin
      drive(hv[i], 10, 10);
      tick();
      n_cmp++;
      if (dig !== ev[i] || range_err !== 1'b0) begin
        n_bad++;
        $display("FAIL boundary_h%0d: dig=%h err=%b want %h 0",
                 hv[i], dig, range_err, ev[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(12, 34, 56);
    tick();
    n_cmp++;
    if (dig !== 24'h123456) begin
      n_bad++;
      $display("FAIL hold_load: dig=%h want 123456", dig);
    end
    en = 1'b0;
    drive(1, 2, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (dig !== 24'h123456 || range_err !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d: dig=%h err=%b want 123456 0",
                 i, dig, range_err);
      end
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (dig !== 24'h010203) begin
      n_bad++;
      $display("FAIL hold_release: dig=%h want 010203", dig);
    end
  endtask

  task automatic test_range();
    drive(31, 60, 63);
    tick();
    n_cmp++;
    if (dig !== 24'h235959 || range_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_all: dig=%h err=%b want 235959 1",
               dig, range_err);
    end
    drive(7, 8, 9);
    tick();
    n_cmp++;
    if (dig !== 24'h070809 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL range_clear: dig=%h err=%b want 070809 0",
               dig, range_err);
    end
    drive(24, 45, 30);
    tick();
    n_cmp++;
    if (dig !== 24'h234530 || range_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_hrs24: dig=%h err=%b want 234530 1",
               dig, range_err);
    end
    drive(5, 6, 60);
    tick();
    n_cmp++;
    if (dig !== 24'h050659 || range_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_sec60: dig=%h err=%b want 050659 1",
               dig, range_err);
    end
    // Error flag must hold with the digits while en is low.
    en = 1'b0;
    drive(1, 1, 1);
    tick();
    n_cmp++;
    if (dig !== 24'h050659 || range_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_hold: dig=%h err=%b want 050659 1",
               dig, range_err);
    end
    en = 1'b1;
  endtask

  task automatic test_mid_reset();
    drive(21, 43, 17);
    tick();
    n_cmp++;
    if (dig !== 24'h214317) begin
      n_bad++;
      $display("FAIL midrst_load: dig=%h want 214317", dig);
    end
    drive(31, 63, 63);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dig !== 24'h0 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst: dig=%h err=%b want 000000 0",
               dig, range_err);
    end
    tick();
    n_cmp++;
    if (dig !== 24'h0 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_held: dig=%h err=%b want 000000 0",
               dig, range_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int bad_here;
    for (int h = 0; h < 24; h++) begin
      for (int m = 0; m < 60; m++) begin
        drive(h, m, 59 - m);
        tick();
        bad_here = 0;
        if (int'(outhrstens) * 10 + int'(outhrsones) != h)
          bad_here = 1;
        if (int'(outmintens) * 10 + int'(outminones) != m)
          bad_here = 1;
        if (int'(outsectens) * 10 + int'(outsecones) != 59 - m)
          bad_here = 1;
        if (outhrsones > 4'd9 || outminones > 4'd9 ||
            outsecones > 4'd9 || range_err !== 1'b0)
          bad_here = 1;
        n_cmp++;
        if (bad_here != 0) begin
          n_bad++;
          $display("FAIL sweep %0d:%0d:%0d: dig=%h err=%b",
                   h, m, 59 - m, dig, range_err);
        end
      end
    end
  endtask

`ifdef DISPLAY_DECODER_SEG_EN
  task automatic test_seg();
    drive(18, 18, 18);
    tick();
    n_cmp++;
    if (seg_hrstens !== 7'b1111001 ||
        seg_mintens !== 7'b1111001 ||
        seg_sectens !== 7'b1111001) begin
      n_bad++;
      $display("FAIL seg_one: %b %b %b want 1111001",
               seg_hrstens, seg_mintens, seg_sectens);
    end
    n_cmp++;
    if (seg_hrsones !== 7'b0000000 ||
        seg_minones !== 7'b0000000 ||
        seg_secones !== 7'b0000000) begin
      n_bad++;
      $display("FAIL seg_eight: %b %b %b want 0000000",
               seg_hrsones, seg_minones, seg_secones);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_nominal();
    test_boundaries();
    test_hold();
    test_range();
    test_mid_reset();
    test_sweep();
`ifdef DISPLAY_DECODER_SEG_EN
    test_seg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_decoder.md
Name: display_decoder

Overview:
- Converts binary time-of-day values (hours 0-23, minutes 0-59, seconds 0-59) into six 4-bit BCD digits (tens/ones per field).
- Sits between the time-keeping counter and the display/multiplexer logic.
- Outputs are registered (one-cycle latency), and out-of-range inputs are flagged and saturated.

Parameters:
- HRS_LIMIT, 24, number of valid hour values; legal hours are 0..HRS_LIMIT-1. Supported values are 12 or 24.
- MS_LIMIT, 60, number of valid minute/second values; legal range is 0..MS_LIMIT-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture/update enable; when low, outputs hold.
- numhrs  input  5  binary hours.
- nummin  input  6  binary minutes.
- numsec  input  6  binary seconds.
- outhrstens  output  4  BCD hours tens digit.
- outhrsones  output  4  BCD hours ones digit.
- outmintens  output  4  BCD minutes tens digit.
- outminones  output  4  BCD minutes ones digit.
- outsectens  output  4  BCD seconds tens digit.
- outsecones  output  4  BCD seconds ones digit.
- range_err  output  1  high when the last captured sample had any field out of range.

Behaviour:
- Reset (rst_n low, asynchronous): all six digit outputs go to 0 and range_err goes to 0. Release is synchronous to clk.
- Rising clk with en=1: inputs are sampled, converted, and the results are registered. Outputs reflect the sample one clock later; latency is exactly 1 cycle.
- Rising clk with en=0: all outputs hold their previous values.
- Conversion: tens = value / 10, ones = value % 10. Pure combinational divide-by-10 (or double-dabble) ahead of the registers; no multi-cycle iteration.
- Tens digit ranges: hours tens 0..2, minutes/seconds tens 0..5. Ones digits 0..9. No digit may ever output 10-15.
- Saturation when a field is out of range (hours >= HRS_LIMIT, minutes or seconds >= MS_LIMIT):
  - that field is clamped to its maximum (23, or 11 when HRS_LIMIT=12; 59 for min/sec) before conversion;
  - other fields convert normally;
  - range_err is registered high for that sample.
- range_err is recomputed on every enabled sample; it is not sticky.
- Boundary values 0, 9, 10, 19, 20, 23 and 59 must convert exactly. Hours 23 gives 2/3; 59 gives 5/9.
- Reset asserted mid-operation clears the outputs immediately, regardless of en or clk.

Optional Feature:
- Macro: DISPLAY_DECODER_SEG_EN.
- When defined:
  - adds six 7-bit outputs seg_hrstens, seg_hrsones, seg_mintens, seg_minones, seg_sectens, seg_secones;
  - each is the active-low seven-segment pattern (bit order g..a) of the matching BCD digit, for common-anode boards;
  - registered in the same stage as the BCD outputs, so latency is also 1 cycle;
  - reset value is 7'b1000000 (digit 0 pattern).
- When undefined: these ports and their logic do not exist, and BCD behaviour is unchanged.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all digits 0 and range_err=0 immediately, before any clk edge.
- Nominal: en=1, hrs=23, min=59, sec=59 -> after 1 clk: 2,3,5,9,5,9 and range_err=0. Then hrs=0, min=0, sec=0 -> 0,0,0,0,0,0.
- Digit boundaries: hrs=9/10/19/20 with min=sec=10 -> hours 0/9, 1/0, 1/9, 2/0; minutes and seconds 1/0.
- Hold: load 12:34:56, drop en, change inputs to 01:02:03 -> outputs stay 1,2,3,4,5,6 across 5 clocks.
- Out of range: hrs=31, min=60, sec=63 -> 2,3,5,9,5,9 with range_err=1. Next sample 07:08:09 -> 0,7,0,8,0,9 with range_err=0.
- Exhaustive sweep: all hrs 0..23 with min=sec swept 0..59 -> tens*10+ones equals input on every sample. With DISPLAY_DECODER_SEG_EN, also check digit 8 -> 7'b0000000 and digit 1 -> 7'b1111001.
